// File: rtl/tmr_vote_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tmr_vote_ctrl
// Brief    : Collects three redundant channels, votes them, tracks faulty ones.
// Revision : 1.0  initial release
// ============================================================================
module tmr_vote_ctrl #(
  parameter int W       = 8,
  parameter int TIMEOUT = 15,
  parameter int ERR_MAX = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2:0]     in_valid,
  input  logic [3*W-1:0] in_data,
  output logic [2:0]     in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  input  logic           out_ready,
  output logic           out_degraded,
  output logic           out_err,
  output logic [2:0]     fault,
  input  logic           clear_fault
);

  localparam int c_tmo_w = $clog2(TIMEOUT + 1);
  localparam int c_err_w = $clog2(ERR_MAX + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);
  localparam logic [c_err_w-1:0] c_err_max  = c_err_w'(ERR_MAX);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VOTE    = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t                    r_state;
  logic [2:0]                r_cap;
  logic [W-1:0]              r_data [3];
  logic [c_tmo_w-1:0]        r_tmo;
  logic [2:0][c_err_w-1:0]   r_err_cnt;
  logic [2:0]                r_fault;
  logic                      r_out_valid;
  logic [W-1:0]              r_out_data;
  logic                      r_out_deg;
  logic                      r_out_err;

  logic [2:0]                w_take;
  logic [2:0]                w_cap_nx;
  logic                      w_all_in;
  logic                      w_timeout;
  logic [W-1:0]              w_vote_data;
  logic                      w_vote_deg;
  logic                      w_vote_err;
  logic [2:0][c_err_w-1:0]   w_err_inc;
  logic [2:0][c_err_w-1:0]   w_err_nx;
  logic [2:0]                w_fault_hit;

  assign in_ready     = (r_state == COLLECT && !rst) ? (~r_cap & ~r_fault) : 3'b000;
  assign w_take       = in_valid & in_ready;
  assign w_cap_nx     = r_cap | w_take;
  // An all-faulty set has no healthy channel, so it must never satisfy "all in".
  assign w_all_in     = (w_cap_nx != 3'b000) && ((~r_fault & ~w_cap_nx) == 3'b000);
  assign w_timeout    = (r_cap != 3'b000) && (r_tmo == c_tmo_last);

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_degraded = r_out_deg;
  assign out_err      = r_out_err;
  assign fault        = r_fault;

  always_comb begin
    w_vote_data = '0;
    w_vote_deg  = 1'b0;
    w_vote_err  = 1'b0;
    case (r_cap)
      3'b111: w_vote_data = (r_data[0] & r_data[1]) | (r_data[0] & r_data[2]) |
                            (r_data[1] & r_data[2]);
      3'b011: begin
        w_vote_data = r_data[0];
        w_vote_deg  = 1'b1;
        w_vote_err  = (r_data[0] != r_data[1]);
      end
      3'b101: begin
        w_vote_data = r_data[0];
        w_vote_deg  = 1'b1;
        w_vote_err  = (r_data[0] != r_data[2]);
      end
      3'b110: begin
        w_vote_data = r_data[1];
        w_vote_deg  = 1'b1;
        w_vote_err  = (r_data[1] != r_data[2]);
      end
      3'b001: begin
        w_vote_data = r_data[0];
        w_vote_deg  = 1'b1;
      end
      3'b010: begin
        w_vote_data = r_data[1];
        w_vote_deg  = 1'b1;
      end
      3'b100: begin
        w_vote_data = r_data[2];
        w_vote_deg  = 1'b1;
      end
      default: ;
    endcase
  end

  // Two-operand votes leave participant counters untouched, agree or not.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_fault_hit[i] = (r_err_cnt[i] == c_err_max);
      w_err_inc[i]   = w_fault_hit[i] ? r_err_cnt[i] : r_err_cnt[i] + 1'b1;
      w_err_nx[i]    = r_err_cnt[i];
      if (!r_cap[i]) begin
        if (!r_fault[i]) w_err_nx[i] = w_err_inc[i];
      end else if (r_cap == 3'b111) begin
        w_err_nx[i] = (r_data[i] != w_vote_data) ? w_err_inc[i] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= COLLECT;
      r_cap       <= 3'b000;
      r_tmo       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_deg   <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          for (int i = 0; i < 3; i++) begin
            if (w_take[i]) r_data[i] <= in_data[i*W +: W];
          end
          r_cap <= w_cap_nx;
          if (r_cap != 3'b000) r_tmo <= r_tmo + 1'b1;
          if (w_all_in || w_timeout) r_state <= VOTE;
        end
        VOTE: begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_vote_data;
          r_out_deg   <= w_vote_deg;
          r_out_err   <= w_vote_err;
          r_state     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_cap       <= 3'b000;
            r_tmo       <= '0;
            r_state     <= COLLECT;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_fault) begin
      r_err_cnt <= '0;
      r_fault   <= 3'b000;
    end else begin
      if (r_state == VOTE) r_err_cnt <= w_err_nx;
      r_fault <= r_fault | w_fault_hit;
    end
  end

endmodule
`default_nettype wire

// File: doc/tmr_vote_ctrl.md
TMR_VOTE_CTRL -- requirements
Module: tmr_vote_ctrl

Interface
REQ-001 Parameter W, default 8: data width of each redundant channel.
REQ-002 Parameter TIMEOUT, default 15: collection window in cycles, counted from the first capture.
REQ-003 Parameter ERR_MAX, default 3: consecutive disagreements that mark a channel faulty.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 in_valid  in  3  per-channel data valid; bit i is channel i.
REQ-007 in_data  in  3*W  channel i data at bits [i*W +: W].
REQ-008 in_ready  out  3  per-channel accept.
REQ-009 out_valid  out  1  voted result valid.
REQ-010 out_data  out  W  voted result.
REQ-011 out_ready  in  1  consumer accept.
REQ-012 out_degraded  out  1  fewer than 3 operands took part in the vote.
REQ-013 out_err  out  1  two-operand vote disagreed.
REQ-014 fault  out  3  sticky faulty-channel mask.
REQ-015 clear_fault  in  1  clears fault mask and all error counters.

Function
REQ-016 FSM states SHALL be COLLECT, VOTE and OUTPUT; reset state is COLLECT.
REQ-017 In COLLECT, in_ready[i] SHALL be 1 when channel i is not captured, fault[i]=0 and rst=0; otherwise 0.
REQ-018 A capture SHALL occur on in_valid[i]&in_ready[i]; the data is registered and channel i is marked captured.
REQ-019 The timeout counter SHALL start on the cycle after the first capture; with zero captures COLLECT SHALL wait indefinitely.
REQ-020 COLLECT SHALL go to VOTE after all healthy channels are captured, or once TIMEOUT cycles have elapsed since the first capture.
REQ-021 VOTE SHALL last one cycle, then go to OUTPUT; out_valid SHALL rise 2 cycles after the cycle of the last capture handshake.
REQ-022 Three operands: out_data SHALL be the bitwise majority; out_degraded=0 and out_err=0.
REQ-023 Two operands: if equal, out_data SHALL be that value and out_err=0; if unequal, out_data SHALL be the lower-index value and out_err=1; out_degraded=1.
REQ-024 One operand: out_data SHALL be that value, out_degraded=1 and out_err=0.
REQ-025 Error counters, per channel, saturating at ERR_MAX, updated in VOTE:
  - Three-operand vote: +1 if the channel differs from the result in any bit, else cleared to 0.
  - Any vote: a healthy channel that was not captured gets +1.
  - Two-operand disagreement: counters of the two participants unchanged.
REQ-026 fault[i] SHALL be set on the cycle after counter i reaches ERR_MAX and SHALL remain set until clear_fault or rst.
REQ-027 A fault change SHALL apply from the next COLLECT; a channel already captured stays in the current vote.
REQ-028 In OUTPUT, out_valid, out_data, out_degraded and out_err SHALL hold stable until out_ready; in_ready SHALL be 0.
REQ-029 On out_valid&out_ready the FSM SHALL return to COLLECT and clear all captured marks; the next capture may happen in the following cycle.
REQ-030 When fault=3'b111, the block SHALL remain in COLLECT with in_ready=0 until clear_fault.
REQ-031 If clear_fault and a fault set occur in the same cycle, clear_fault SHALL win.

Reset
REQ-032 While rst=1 on a clock edge: state becomes COLLECT; captured marks, timeout counter, error counters and fault are cleared.
REQ-033 Output values in reset: in_ready=0, out_valid=0, out_data=0, out_degraded=0, out_err=0.
REQ-034 Reset SHALL abort any transaction in progress, with no output produced for it; rst takes priority over every other input.

Verification (W=8, TIMEOUT=15, ERR_MAX=3)
REQ-035 Input 0xA5 on all channels in one cycle -> out_valid 2 cycles later, out_data=0xA5, degraded=0, err=0.
REQ-036 Input ch0..2 = 0xC3, 0x5A, 0x3C -> out_data=0x5A; ch0 and ch2 counters become 1, ch1 counter becomes 0.
REQ-037 Input 0x0F, 0x0F, 0xF0 three times -> fault=3'b100 after the third vote; next transaction in_ready=3'b011; input 0x22, 0x22 -> out_data=0x22, degraded=1.
REQ-038 Input ch0 and ch1 = 0x11, ch2 silent -> VOTE after 15 cycles, out_data=0x11, degraded=1, err=0; ch2 counter becomes 1.
REQ-039 Hold out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0; accept on cycle 6 -> COLLECT.
REQ-040 Assert rst after ch0 is captured -> no output; in_ready=3'b111 on the cycle after rst deasserts. Assert clear_fault with fault=3'b111 -> fault=0 and in_ready=3'b111 on the next cycle.
